// File: rtl/blkmem_dma.sv
// Block copy / block fill bus initiator for the single-cycle memory bus.
// One word per cycle for fill, two cycles per word for copy at zero wait.
module blkmem_dma #(
    parameter int DEPTH = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [DEPTH-1:0] i_src,
    input  logic [DEPTH-1:0] i_dst,
    input  logic [DEPTH:0]   i_len,
    input  logic [15:0]      i_fill,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cyc,
    output logic             o_we,
    output logic [DEPTH-1:0] o_addr,
    output logic [15:0]      o_dat,
    input  logic [15:0]      i_dat,
    input  logic             i_ack
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state;
    logic             mode;
    logic [DEPTH-1:0] src;
    logic [DEPTH-1:0] dst;
    logic [DEPTH:0]   len;
    logic [DEPTH:0]   idx;
    logic [DEPTH:0]   idx_n;

    assign idx_n = idx + 1'b1;

    // o_dat doubles as the data buffer: it holds the read word in copy
    // mode and the latched fill value in fill mode.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            mode   <= 1'b0;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            idx    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_cyc  <= 1'b0;
            o_we   <= 1'b0;
            o_addr <= '0;
            o_dat  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        mode <= i_mode;
                        src  <= i_src;
                        dst  <= i_dst;
                        len  <= i_len;
                        idx  <= '0;
                        if (i_len == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else if (!i_mode) begin
                            state  <= READ;
                            o_busy <= 1'b1;
                            o_cyc  <= 1'b1;
                            o_we   <= 1'b0;
                            o_addr <= i_src;
                        end else begin
                            state  <= WRITE;
                            o_busy <= 1'b1;
                            o_cyc  <= 1'b1;
                            o_we   <= 1'b1;
                            o_addr <= i_dst;
                            o_dat  <= i_fill;
                        end
                    end
                end
                READ: begin
                    if (i_ack) begin
                        state  <= WRITE;
                        o_we   <= 1'b1;
                        o_addr <= dst + idx[DEPTH-1:0];
                        o_dat  <= i_dat;
                    end
                end
                WRITE: begin
                    if (i_ack) begin
                        idx <= idx_n;
                        if (idx_n == len) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_cyc  <= 1'b0;
                            o_we   <= 1'b0;
                            o_done <= 1'b1;
                        end else if (!mode) begin
                            state  <= READ;
                            o_we   <= 1'b0;
                            o_addr <= src + idx_n[DEPTH-1:0];
                        end else begin
                            o_addr <= dst + idx_n[DEPTH-1:0];
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blkmem_dma.sv
// Self-checking bench for blkmem_dma: bus-level access model plus memory image.
// Expected accesses are derived from the transfer rules, not the DUT state.
module tb_blkmem_dma;

    localparam int DEPTH = 12;
    localparam int NW = 1 << DEPTH;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_start = 1'b0;
    logic             i_mode = 1'b0;
    logic [DEPTH-1:0] i_src = '0;
    logic [DEPTH-1:0] i_dst = '0;
    logic [DEPTH:0]   i_len = '0;
    logic [15:0]      i_fill = '0;
    logic             o_busy;
    logic             o_done;
    logic             o_cyc;
    logic             o_we;
    logic [DEPTH-1:0] o_addr;
    logic [15:0]      o_dat;
    logic [15:0]      i_dat;
    logic             i_ack;

    blkmem_dma #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_mode(i_mode), .i_src(i_src), .i_dst(i_dst),
        .i_len(i_len), .i_fill(i_fill), .o_busy(o_busy),
        .o_done(o_done), .o_cyc(o_cyc), .o_we(o_we),
        .o_addr(o_addr), .o_dat(o_dat), .i_dat(i_dat),
        .i_ack(i_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic             we;
        logic [DEPTH-1:0] addr;
        logic [15:0]      dat;
    } acc_t;

    logic [15:0] mem [NW];
    logic [15:0] mdl [NW];
    acc_t        expq [$];
    int          ws = 0;
    int          wcnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_done = 0;
    logic        p_stall = 1'b0;
    acc_t        p_acc;

    assign i_ack = o_cyc && (wcnt >= ws);
    assign i_dat = mem[o_addr];

    always @(posedge i_clk) begin
        if (o_cyc && o_we && i_ack) mem[o_addr] <= o_dat;
        if (i_reset || !o_cyc || i_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare against the expected access stream
    always @(negedge i_clk) begin
        acc_t e;
        if (i_reset) begin
            p_stall = 1'b0;
        end else begin
            check("busy_eq_cyc", o_busy, o_cyc);
            if (o_done) n_done++;
            if (p_stall) begin
                check("hold_cyc", o_cyc, 1);
                check("hold_we", o_we, p_acc.we);
                check("hold_addr", o_addr, p_acc.addr);
                if (p_acc.we) check("hold_dat", o_dat, p_acc.dat);
            end
            if (o_cyc && i_ack) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_bus: got addr %0h we %0b expected none",
                             o_addr, o_we);
                end else begin
                    e = expq.pop_front();
                    check("acc_we", o_we, e.we);
                    check("acc_addr", o_addr, e.addr);
                    if (e.we) check("acc_dat", o_dat, e.dat);
                end
            end
            p_stall = o_cyc && !i_ack;
            p_acc = acc_t'{o_we, o_addr, o_dat};
        end
    end

    task automatic plan(bit mode, int src, int dst, int len, int fill);
        logic [DEPTH-1:0] s, d;
        logic [15:0] v;
        for (int i = 0; i < len; i++) begin
            s = DEPTH'(src + i);
            d = DEPTH'(dst + i);
            if (!mode) begin
                v = mdl[s];
                expq.push_back(acc_t'{1'b0, s, 16'h0});
            end else begin
                v = 16'(fill);
            end
            mdl[d] = v;
            expq.push_back(acc_t'{1'b1, d, v});
        end
    endtask

    task automatic run(bit mode, int src, int dst, int len, int fill,
                       bit poke, output int bc);
        int k;
        int exp_bc;
        exp_bc = len * (mode ? 1 : 2) * (ws + 1);
        plan(mode, src, dst, len, fill);
        i_mode = mode;
        i_src = DEPTH'(src);
        i_dst = DEPTH'(dst);
        i_len = (DEPTH+1)'(len);
        i_fill = 16'(fill);
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        k = 0;
        bc = 0;
        while (k < 300) begin
            @(negedge i_clk);
            k++;
            if (o_busy) bc++;
            if (poke && k == 2) begin
                i_start = 1'b1;
                i_mode = ~mode;
                i_dst = 12'h040;
                i_len = 13'd1;
            end
            if (poke && k == 3) begin
                i_start = 1'b0;
                i_mode = mode;
                i_dst = DEPTH'(dst);
                i_len = (DEPTH+1)'(len);
            end
            if (o_done) break;
        end
        check("done_latency", k, exp_bc + 1);
        check("busy_cycles", bc, exp_bc);
        check("queue_drained", expq.size(), 0);
        @(negedge i_clk);
        check("done_width", o_done, 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int bc;
        int k;
        int nd;
        int bad;
        for (int a = 0; a < NW; a++) begin
            mem[a] = 16'h0;
            mdl[a] = 16'h0;
        end
        mem[12'h100] = 16'h1111; mdl[12'h100] = 16'h1111;
        mem[12'h101] = 16'h2222; mdl[12'h101] = 16'h2222;
        mem[12'h102] = 16'h3333; mdl[12'h102] = 16'h3333;
        mem[12'h300] = 16'hCAFE; mdl[12'h300] = 16'hCAFE;
        mem[12'h301] = 16'h1234; mdl[12'h301] = 16'h1234;
        mem[12'h500] = 16'h0A0A; mdl[12'h500] = 16'h0A0A;
        mem[12'h501] = 16'h0B0B; mdl[12'h501] = 16'h0B0B;
        mem[12'h502] = 16'h0C0C; mdl[12'h502] = 16'h0C0C;

        repeat (3) @(negedge i_clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cyc", o_cyc, 0);
        check("rst_we", o_we, 0);
        check("rst_addr", o_addr, 0);
        check("rst_dat", o_dat, 0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        run(1'b1, 0, 12'h010, 4, 16'hBEEF, 1'b0, bc);
        check("fill_busy_lit", bc, 4);
        for (int i = 0; i < 4; i++)
            check("fill_mem", mem[12'h010 + i], 16'hBEEF);

        run(1'b0, 12'h100, 12'h200, 3, 0, 1'b0, bc);
        check("copy_busy_lit", bc, 6);
        check("copy_mem0", mem[12'h200], 16'h1111);
        check("copy_mem1", mem[12'h201], 16'h2222);
        check("copy_mem2", mem[12'h202], 16'h3333);

        ws = 2;
        run(1'b0, 12'h300, 12'h310, 2, 0, 1'b0, bc);
        ws = 0;
        check("ws_busy_lit", bc, 12);
        check("ws_mem0", mem[12'h310], 16'hCAFE);
        check("ws_mem1", mem[12'h311], 16'h1234);

        run(1'b1, 0, 12'h020, 0, 16'hFFFF, 1'b0, bc);
        check("len0_busy", bc, 0);
        check("len0_mem", mem[12'h020], 16'h0000);

        run(1'b1, 0, 12'hFFE, 4, 16'h5A5A, 1'b0, bc);
        check("wrap_ffe", mem[12'hFFE], 16'h5A5A);
        check("wrap_fff", mem[12'hFFF], 16'h5A5A);
        check("wrap_000", mem[12'h000], 16'h5A5A);
        check("wrap_001", mem[12'h001], 16'h5A5A);

        nd = n_done;
        plan(1'b1, 0, 12'h400, 8, 16'hA5A5);
        for (int i = 2; i < 8; i++) mdl[12'h400 + i] = 16'h0;
        i_mode = 1'b1;
        i_dst = 12'h400;
        i_len = 13'd8;
        i_fill = 16'hA5A5;
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        k = 0;
        while (k < 50 && !(o_cyc && o_addr == 12'h402)) begin
            @(negedge i_clk);
            k++;
        end
        check("rst_reach_word3", o_addr, 12'h402);
        i_reset = 1'b1;
        #1;
        check("arst_cyc", o_cyc, 0);
        check("arst_busy", o_busy, 0);
        expq.delete();
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("arst_no_done", n_done, nd);
        check("arst_w1", mem[12'h401], 16'hA5A5);
        check("arst_w2", mem[12'h402], 16'h0000);
        check("arst_w7", mem[12'h407], 16'h0000);

        run(1'b1, 0, 12'h600, 3, 16'h7777, 1'b0, bc);
        check("restart_mem", mem[12'h602], 16'h7777);

        run(1'b0, 12'h100, 12'h700, 3, 0, 1'b1, bc);
        check("poke_mem0", mem[12'h700], 16'h1111);
        check("poke_mem2", mem[12'h702], 16'h3333);
        check("poke_040", mem[12'h040], 16'h0000);

        run(1'b0, 12'h500, 12'h501, 3, 0, 1'b0, bc);
        check("ovl_501", mem[12'h501], 16'h0A0A);
        check("ovl_503", mem[12'h503], 16'h0A0A);

        bad = 0;
        for (int a = 0; a < NW; a++)
            if (mem[a] !== mdl[a]) bad++;
        check("mem_image", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/blkmem_dma.md
Name: blkmem_dma

Overview:
- Bus initiator for the single-cycle memory bus served by the block memory (cyc/we/addr/dat).
- Performs block copy (memory-to-memory) or block fill (constant-to-memory) of up to 2**DEPTH 16-bit words.
- Gives the d16 system a way to move or clear memory without CPU involvement.
- Sits between a control source (CPU register file or testbench) and one memory port.

Parameters:
- DEPTH, 12, address width in bits; memory holds 2**DEPTH words.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_start  input  1  start request, sampled in IDLE only.
- i_mode  input  1  0 = copy, 1 = fill.
- i_src  input  DEPTH  copy source start address.
- i_dst  input  DEPTH  destination start address.
- i_len  input  DEPTH+1  word count, 0..2**DEPTH.
- i_fill  input  16  fill value.
- o_busy  output  1  high while a transfer is active.
- o_done  output  1  one-cycle pulse at transfer completion.
- o_cyc  output  1  bus cycle active.
- o_we  output  1  bus write strobe.
- o_addr  output  DEPTH  bus address.
- o_dat  output  16  bus write data.
- i_dat  input  16  bus read data; valid in the same cycle as address and ack.
- i_ack  input  1  responder acknowledge; the block memory ties it to o_cyc (zero wait).

Behaviour:
- Reset: asynchronous. State goes to IDLE. o_busy, o_done, o_cyc and o_we go to 0. o_addr, o_dat, the index counter and the data buffer go to 0. Reset mid-transfer aborts immediately with no further bus cycles and no o_done.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - o_cyc = 0.
  - On i_start = 1, latch src, dst, len, mode and fill, and clear idx.
  - If len == 0, go to DONE.
  - Else if mode = copy, go to READ.
  - Else go to WRITE.
  - i_start is ignored in every other state.
- READ (copy only):
  - o_cyc = 1, o_we = 0, o_addr = src + idx.
  - When i_ack = 1, capture i_dat into buf and go to WRITE.
  - Without ack, hold and stay.
- WRITE:
  - o_cyc = 1, o_we = 1, o_addr = dst + idx.
  - o_dat = buf in copy mode, fill value in fill mode.
  - When i_ack = 1, idx <= idx + 1.
  - If idx + 1 == len, go to DONE.
  - Otherwise go to READ (copy) or stay in WRITE with the next address (fill).
  - Without ack, hold all bus outputs stable.
- DONE:
  - o_cyc = 0, o_done = 1 for exactly one cycle, then IDLE.
  - o_busy = 0 in DONE, so a new start is accepted the following cycle.
- o_busy = 1 in READ and WRITE.
- Address arithmetic is modulo 2**DEPTH: src + idx and dst + idx wrap silently past the top address.
- idx is DEPTH+1 bits wide, so len = 2**DEPTH transfers the whole memory.
- Throughput with zero-wait ack:
  - Fill: 1 word per cycle.
  - Copy: 2 cycles per word.
  - Start-to-first-bus-cycle latency is 1 cycle: i_start sampled at edge N, o_cyc high after edge N.
- Overlapping copy regions are copied in ascending address order with no overlap protection (dst > src with overlap replicates data).

Test Plan:
- Fill, zero-wait ack (ack = cyc): dst = 0x010, len = 4, fill = 0xBEEF -> writes at 0x010..0x013 on 4 consecutive cycles, o_done pulse 1 cycle after the last write, memory reads 0xBEEF at each.
- Copy: preload 0x100..0x102 = 0x1111/0x2222/0x3333, src = 0x100, dst = 0x200, len = 3 -> alternating read/write cycles (6 bus cycles), 0x200..0x202 match, o_busy high exactly 6 cycles.
- Wait states: ack delayed 2 cycles per access during copy len = 2 -> o_addr, o_we and o_dat held stable while ack low, final data correct.
- Boundaries:
  - len = 0 -> no o_cyc, o_done pulse 1 cycle after start.
  - Fill dst = 0xFFE, len = 4 -> writes 0xFFE, 0xFFF, 0x000, 0x001.
- Reset and restart:
  - Assert i_reset during the 3rd word of a len = 8 fill -> o_cyc and o_busy drop asynchronously, no o_done, later writes absent.
  - A new start after reset completes normally.
- i_start pulsed while busy -> ignored; the transfer completes with the originally latched parameters.
